// File: rtl/ysyx_25040105_core_ctrl_if.sv
// Fetch (IFU) and memory (LSU) handshake bundle between the core control FSM
// and its bus agents; master is the control block, slave the IFU/LSU side.
interface ysyx_25040105_core_ctrl_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_inst;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic        lsu_resp_err;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_resp_valid,
        input  ifu_resp_inst,
        output lsu_req_valid,
        output lsu_req_wen,
        input  lsu_req_ready,
        input  lsu_resp_valid,
        input  lsu_resp_err
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_resp_valid,
        output ifu_resp_inst,
        input  lsu_req_valid,
        input  lsu_req_wen,
        output lsu_req_ready,
        output lsu_resp_valid,
        output lsu_resp_err
    );
endinterface

// File: rtl/ysyx_25040105_core_ctrl.sv
// Multi-cycle control FSM of the NPC core: fetch, decode, memory access and
// writeback sequencing, halt/error reporting and cycle/instret counters.
module ysyx_25040105_core_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_25040105_core_ctrl_if.master   bus,
    output logic [31:0]                 inst_o,
    input  logic                        idu_reg_wen_i,
    output logic                        rf_wen_o,
    output logic                        pc_wen_o,
    output logic                        halt_o,
    output logic                        err_o,
    output logic [1:0]                  err_cause_o,
    output logic [CNT_W-1:0]            cycle_cnt_o,
    output logic [CNT_W-1:0]            instret_cnt_o
);

    localparam int             TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_MREQ,
        S_MWAIT,
        S_WB,
        S_HALT,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        inst_q, inst_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;
    logic               terminal;

    logic [6:0] opcode;
    logic       is_ebreak;
    logic       is_mem;
    logic       is_exec;

    assign opcode    = inst_q[6:0];
    assign is_ebreak = (inst_q == INST_EBREAK);
    assign is_mem    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign is_exec   = (opcode == OPC_OP_IMM) || (opcode == OPC_OP)
                    || (opcode == OPC_BRANCH) || (opcode == OPC_JAL)
                    || (opcode == OPC_JALR)   || (opcode == OPC_AUIPC)
                    || (opcode == OPC_LUI);
    assign terminal  = (state_q == S_HALT) || (state_q == S_ERR);

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        timer_d = timer_q;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.ifu_req_ready) begin
                    state_d = S_FWAIT;
                    timer_d = '0;
                end
            end
            S_FWAIT: begin
                if (bus.ifu_resp_valid) begin
                    inst_d  = bus.ifu_resp_inst;
                    state_d = S_DECODE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERR;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DECODE: begin
                // ebreak must be matched on the full word before the opcode
                // classes: every other SYSTEM encoding is illegal here.
                if (is_ebreak) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (is_mem) begin
                    state_d = S_MREQ;
                end else if (is_exec) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_ERR;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_MREQ: begin
                if (bus.lsu_req_ready) begin
                    state_d = S_MWAIT;
                    timer_d = '0;
                end
            end
            S_MWAIT: begin
                // A response arriving on the last timer cycle beats the timeout.
                if (bus.lsu_resp_valid) begin
                    if (bus.lsu_resp_err) begin
                        state_d = S_ERR;
                        cause_d = CAUSE_BUS;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERR;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            inst_q    <= INST_NOP;
            timer_q   <= '0;
            cause_q   <= CAUSE_NONE;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            timer_q <= timer_d;
            cause_q <= cause_d;
            if (!terminal) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign bus.ifu_req_valid = (state_q == S_FETCH);
    assign bus.lsu_req_valid = (state_q == S_MREQ);
    assign bus.lsu_req_wen   = (state_q == S_MREQ) && (opcode == OPC_STORE);

    assign inst_o        = inst_q;
    assign rf_wen_o      = (state_q == S_WB) && idu_reg_wen_i;
    assign pc_wen_o      = (state_q == S_WB);
    assign halt_o        = (state_q == S_HALT);
    assign err_o         = (state_q == S_ERR);
    assign err_cause_o   = cause_q;
    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;

endmodule

// File: tb/tb_ysyx_25040105_core_ctrl.sv
// Scoreboard bench for the core control FSM: directed instructions push
// expected events; a monitor pops and compares as the DUT produces them.
module tb_ysyx_25040105_core_ctrl;

    localparam int EV_LSU  = 0;
    localparam int EV_WB   = 1;
    localparam int EV_HALT = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int    kind;
        logic  bitv;
        int    instret;
        int    cycle;
        int    cause;
        string name;
    } ev_t;

    typedef struct {
        int delay;
        bit err;
    } lsu_cfg_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        idu_reg_wen;
    logic        rf_wen;
    logic        pc_wen;
    logic        halt;
    logic        err;
    logic [1:0]  err_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int checks = 0;
    int errors = 0;

    ev_t      sb[$];
    lsu_cfg_t lsu_cfg_q[$];
    bit       pend;
    ev_t      pend_ev;

    ysyx_25040105_core_ctrl_if bus ();

    ysyx_25040105_core_ctrl #(
        .TIMEOUT_CYC (16),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .inst_o        (inst),
        .idu_reg_wen_i (idu_reg_wen),
        .rf_wen_o      (rf_wen),
        .pc_wen_o      (pc_wen),
        .halt_o        (halt),
        .err_o         (err),
        .err_cause_o   (err_cause),
        .cycle_cnt_o   (cycle_cnt),
        .instret_cnt_o (instret_cnt)
    );

    // Decoder stand-in: stores and branches do not write the register file.
    assign idu_reg_wen = !((inst[6:0] == 7'b0100011) || (inst[6:0] == 7'b1100011));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic bitv, input int ir,
                             input int cy, input int cause, input string name);
        ev_t e;
        e.kind = kind; e.bitv = bitv; e.instret = ir;
        e.cycle = cy; e.cause = cause; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_lsu(input int delay, input bit err_f);
        lsu_cfg_t c;
        c.delay = delay; c.err = err_f;
        lsu_cfg_q.push_back(c);
    endtask

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{kind: -1, bitv: 1'b0, instret: 0, cycle: 0, cause: 0, name: "none"};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got event kind %0d required no event", kind);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_kind"}, kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // Monitor: one pass per falling edge; WB events are followed by a
    // check of the counters and request line in the following cycle.
    initial begin : monitor
        bit  halt_prev, err_prev, ok;
        ev_t e;
        halt_prev = 1'b0;
        err_prev  = 1'b0;
        pend      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                halt_prev = 1'b0;
                err_prev  = 1'b0;
                pend      = 1'b0;
            end else begin
                if (pend) begin
                    chk({pend_ev.name, "_instret"}, instret_cnt, pend_ev.instret);
                    chk({pend_ev.name, "_cycle"}, cycle_cnt, pend_ev.cycle);
                    chk({pend_ev.name, "_refetch"}, bus.ifu_req_valid, 1);
                    pend = 1'b0;
                end
                if (bus.lsu_req_valid && bus.lsu_req_ready) begin
                    pop_ev(EV_LSU, e, ok);
                    if (ok) chk({e.name, "_wen"}, bus.lsu_req_wen, e.bitv);
                end
                if (pc_wen || rf_wen) begin
                    pop_ev(EV_WB, e, ok);
                    if (ok) begin
                        chk({e.name, "_rf_wen"}, rf_wen, e.bitv);
                        chk({e.name, "_pc_wen"}, pc_wen, 1);
                        pend_ev = e;
                        pend    = 1'b1;
                    end
                end
                if (halt && !halt_prev) begin
                    pop_ev(EV_HALT, e, ok);
                    if (ok) begin
                        chk({e.name, "_instret"}, instret_cnt, e.instret);
                        chk({e.name, "_cycle"}, cycle_cnt, e.cycle);
                    end
                end
                if (err && !err_prev) begin
                    pop_ev(EV_ERR, e, ok);
                    if (ok) begin
                        chk({e.name, "_cause"}, err_cause, e.cause);
                        chk({e.name, "_instret"}, instret_cnt, e.instret);
                        chk({e.name, "_cycle"}, cycle_cnt, e.cycle);
                    end
                end
                halt_prev = halt;
                err_prev  = err;
            end
        end
    end

    // LSU agent: accepts every request, answers after the configured number
    // of silent MWAIT cycles (negative delay: never answers).
    initial begin : lsu_agent
        lsu_cfg_t c;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.lsu_req_valid && bus.lsu_req_ready) begin
                c.delay = -1; c.err = 1'b0;
                if (lsu_cfg_q.size() != 0) c = lsu_cfg_q.pop_front();
                if (c.delay >= 0) begin
                    repeat (c.delay + 1) @(negedge clk);
                    if (rst_n) begin
                        bus.lsu_resp_valid = 1'b1;
                        bus.lsu_resp_err   = c.err;
                    end
                    @(negedge clk);
                    bus.lsu_resp_valid = 1'b0;
                    bus.lsu_resp_err   = 1'b0;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] word, input bit give_resp);
        int n = 0;
        while (!bus.ifu_req_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ifu_req_valid) begin
            chk("fetch_req_timeout", bus.ifu_req_valid, 1);
        end else begin
            bus.ifu_req_ready = 1'b1;
            @(negedge clk);
            bus.ifu_req_ready = 1'b0;
            if (give_resp) begin
                bus.ifu_resp_valid = 1'b1;
                bus.ifu_resp_inst  = word;
                @(negedge clk);
                bus.ifu_resp_valid = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || pend) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", tag}, sb.size(), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lsu_cfg_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish required finish before 300000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n              = 1'b0;
        bus.ifu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_resp_inst  = 32'h0;
        bus.lsu_req_ready  = 1'b1;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("rst_ifu_req_valid", bus.ifu_req_valid, 1);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_lsu_req_valid", bus.lsu_req_valid, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_pc_wen", pc_wen, 0);
        chk("rst_halt", halt, 0);
        chk("rst_err", err, 0);
        chk("rst_cause", err_cause, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_instret", instret_cnt, 0);
        rst_n = 1'b1;

        // 1: addi, zero-wait fetch -> WB in cycle index 3, counters 1/4 after
        $display("test 1: addi x1,x0,5");
        expect_ev(EV_WB, 1'b1, 1, 4, 0, "addi");
        fetch(32'h0050_0093, 1'b1);
        drain("addi");

        // 2: lw with response 3 cycles late, then sw zero-wait
        $display("test 2: lw then sw");
        apply_reset();
        push_lsu(3, 1'b0);
        push_lsu(0, 1'b0);
        expect_ev(EV_LSU, 1'b0, 0, 0, 0, "lw_req");
        expect_ev(EV_WB,  1'b1, 1, 9, 0, "lw_wb");
        expect_ev(EV_LSU, 1'b1, 0, 0, 0, "sw_req");
        expect_ev(EV_WB,  1'b0, 2, 15, 0, "sw_wb");
        fetch(32'h0000_A103, 1'b1);
        fetch(32'h0020_A023, 1'b1);
        drain("lw_sw");

        // 3: ebreak halts, stray fetch responses ignored, counters frozen
        $display("test 3: ebreak");
        apply_reset();
        expect_ev(EV_HALT, 1'b0, 1, 3, 0, "ebreak");
        fetch(32'h0010_0073, 1'b1);
        drain("ebreak");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ifu_resp_valid = 1'b1;
            bus.ifu_resp_inst  = 32'h0050_0093;
            @(negedge clk);
            bus.ifu_resp_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("halt_sticky", halt, 1);
        chk("halt_cycle_frozen", cycle_cnt, 3);
        chk("halt_instret_frozen", instret_cnt, 1);
        chk("halt_inst_held", inst, 32'h0010_0073);
        chk("halt_no_fetch", bus.ifu_req_valid, 0);
        chk("halt_no_err", err, 0);

        // 4: illegal opcode and ecall both trap with cause 1
        $display("test 4: illegal and ecall");
        apply_reset();
        expect_ev(EV_ERR, 1'b0, 0, 3, 1, "illegal");
        fetch(32'hFFFF_FFFF, 1'b1);
        drain("illegal");
        repeat (3) @(negedge clk);
        chk("illegal_err_sticky", err, 1);
        chk("illegal_cause_held", err_cause, 1);
        apply_reset();
        expect_ev(EV_ERR, 1'b0, 0, 3, 1, "ecall");
        fetch(32'h0000_0073, 1'b1);
        drain("ecall");
        chk("ecall_no_halt", halt, 0);

        // 5: memory timeout, bus error, response on the last timeout cycle
        $display("test 5a: lsu timeout");
        apply_reset();
        push_lsu(-1, 1'b0);
        expect_ev(EV_LSU, 1'b0, 0, 0, 0, "to_req");
        expect_ev(EV_ERR, 1'b0, 0, 20, 3, "lsu_timeout");
        fetch(32'h0000_A103, 1'b1);
        drain("lsu_timeout");

        $display("test 5b: lsu bus error");
        apply_reset();
        push_lsu(0, 1'b1);
        expect_ev(EV_LSU, 1'b0, 0, 0, 0, "be_req");
        expect_ev(EV_ERR, 1'b0, 0, 5, 2, "bus_err");
        fetch(32'h0000_A103, 1'b1);
        drain("bus_err");

        $display("test 5c: response on timeout cycle");
        apply_reset();
        push_lsu(15, 1'b0);
        expect_ev(EV_LSU, 1'b0, 0, 0, 0, "late_req");
        expect_ev(EV_WB,  1'b1, 1, 21, 0, "late_wb");
        fetch(32'h0000_A103, 1'b1);
        drain("late");
        chk("late_no_err", err, 0);

        $display("test 5d: fetch timeout");
        apply_reset();
        expect_ev(EV_ERR, 1'b0, 0, 17, 3, "ifu_timeout");
        fetch(32'h0, 1'b0);
        drain("ifu_timeout");

        // 6: asynchronous reset in the middle of MWAIT
        $display("test 6: reset during MWAIT");
        apply_reset();
        push_lsu(-1, 1'b0);
        expect_ev(EV_LSU, 1'b0, 0, 0, 0, "ar_req");
        fetch(32'h0000_A103, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ifu_req_valid", bus.ifu_req_valid, 1);
        chk("ar_lsu_req_valid", bus.lsu_req_valid, 0);
        chk("ar_inst", inst, 32'h0000_0013);
        chk("ar_cycle", cycle_cnt, 0);
        chk("ar_rf_pc_wen", {rf_wen, pc_wen}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ar_first_req", bus.ifu_req_valid, 1);
        expect_ev(EV_WB, 1'b1, 1, 4, 0, "ar_addi");
        fetch(32'h0050_0093, 1'b1);
        drain("ar_addi");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
